egress_frame_reader: RTL and testbench

EGRESS_FRAME_READER -- requirements
Module: egress_frame_reader

---
 rtl/egress_pkg.sv | 26 ++
 rtl/egress_frame_reader.sv | 122 ++++++++++++
 tb/tb_egress_frame_reader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/egress_pkg.sv
// Shared types and constants for the egress frame reader.
// Holds the FSM encoding, pointer field layout and the padded-length helper.
package egress_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PTR_RD  = 3'd1,
        ST_PTR_LAT = 3'd2,
        ST_XMIT    = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    localparam int PTR_LEN_MSB = 11;
    localparam int PAD_ALIGN   = 64;
    localparam int LEN_W       = 13;

    typedef logic [LEN_W-1:0] len_t;

    // Round a 12-bit length up to the next PAD_ALIGN boundary (4095 -> 4096).
    function automatic len_t pad_len(input logic [PTR_LEN_MSB:0] len);
        len_t sum;
        sum = len_t'(len) + len_t'(PAD_ALIGN - 1);
        return sum & ~len_t'(PAD_ALIGN - 1);
    endfunction

endpackage

// File: rtl/egress_frame_reader.sv
// Egress frame reader: pops a length pointer, drains the padded frame from the data
// FIFO and streams the real bytes out. Optional frame counter: EGRESS_FRAME_CNT_EN.
module egress_frame_reader
    import egress_pkg::*;
#(
    parameter int IFG = 12
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ptr_fifo_empty,
    output logic        ptr_fifo_rd,
    input  logic [15:0] ptr_fifo_dout,
    output logic        data_fifo_rd,
    input  logic [7:0]  data_fifo_dout,
    output logic        tx_sof,
    output logic        tx_dv,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        len_err
`ifdef EGRESS_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int GAP_W = (IFG > 1) ? $clog2(IFG) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG > 0) ? IFG - 1 : 0);

    state_t            state, state_nxt;
    len_t              len_q;
    len_t              len_pad_q;
    len_t              byte_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              arm;
    logic              tx_dv_q;
    logic              tx_sof_q;

    logic [PTR_LEN_MSB:0] ptr_len;
    logic                 len_zero;
    logic                 xmit_last;
    logic                 unused_hdr;

    assign ptr_len    = ptr_fifo_dout[PTR_LEN_MSB:0];
    assign len_zero   = (ptr_len == '0);
    assign xmit_last  = (byte_cnt == len_pad_q - len_t'(1));
    assign unused_hdr = ^ptr_fifo_dout[15:PTR_LEN_MSB+1];

    // arm delays the first pointer pop by one edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            arm   <= 1'b0;
        end else begin
            state <= state_nxt;
            arm   <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (arm && !ptr_fifo_empty) state_nxt = ST_PTR_RD;
            ST_PTR_RD:  state_nxt = ST_PTR_LAT;
            ST_PTR_LAT: state_nxt = len_zero ? ST_IDLE : ST_XMIT;
            ST_XMIT:    if (xmit_last) state_nxt = ST_GAP;
            ST_GAP:     if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q     <= '0;
            len_pad_q <= '0;
        end else if (state == ST_PTR_LAT) begin
            len_q     <= len_t'(ptr_len);
            len_pad_q <= pad_len(ptr_len);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            byte_cnt <= (state == ST_XMIT) ? byte_cnt + len_t'(1) : '0;
            gap_cnt  <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
        end
    end

    // Read n is issued in XMIT with byte_cnt==n; its byte appears on the FIFO
    // output one cycle later, which is exactly when these flags are visible.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_dv_q  <= 1'b0;
            tx_sof_q <= 1'b0;
        end else begin
            tx_dv_q  <= (state == ST_XMIT) && (byte_cnt < len_q);
            tx_sof_q <= (state == ST_XMIT) && (byte_cnt == '0);
        end
    end

`ifdef EGRESS_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            frame_cnt <= '0;
        else if (state == ST_XMIT && xmit_last)
            frame_cnt <= frame_cnt + 16'd1;
    end
`endif

    assign ptr_fifo_rd  = (state == ST_PTR_RD);
    assign data_fifo_rd = (state == ST_XMIT);
    assign busy         = (state != ST_IDLE);
    assign len_err      = (state == ST_PTR_LAT) && len_zero;
    assign tx_dv        = tx_dv_q;
    assign tx_sof       = tx_sof_q;
    // The data FIFO output is already a register; gating it keeps the one-cycle
    // read-to-tx latency and forces tx_data to 0 whenever tx_dv is low.
    assign tx_data      = tx_dv_q ? data_fifo_dout : 8'h00;

endmodule

// File: tb/tb_egress_frame_reader.sv
// Bench for egress_frame_reader: FIFO models, a per-frame schedule model and
// literal per-frame totals. Honors EGRESS_FRAME_CNT_EN when defined.
module tb_egress_frame_reader;

    localparam int IFG = 12;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ptr_fifo_empty;
    logic        ptr_fifo_rd;
    logic [15:0] ptr_fifo_dout = '0;
    logic        data_fifo_rd;
    logic [7:0]  data_fifo_dout = '0;
    logic        tx_sof;
    logic        tx_dv;
    logic [7:0]  tx_data;
    logic        busy;
    logic        len_err;
`ifdef EGRESS_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    always #5 clk = ~clk;

    egress_frame_reader #(.IFG(IFG)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .ptr_fifo_empty (ptr_fifo_empty),
        .ptr_fifo_rd    (ptr_fifo_rd),
        .ptr_fifo_dout  (ptr_fifo_dout),
        .data_fifo_rd   (data_fifo_rd),
        .data_fifo_dout (data_fifo_dout),
        .tx_sof         (tx_sof),
        .tx_dv          (tx_dv),
        .tx_data        (tx_data),
        .busy           (busy),
        .len_err        (len_err)
`ifdef EGRESS_FRAME_CNT_EN
        ,
        .frame_cnt      (frame_cnt)
`endif
    );

    // FIFO storage written by the stimulus thread, popped by the DUT strobes.
    logic [15:0] pmem [0:63];
    logic [7:0]  dmem [0:8191];
    int p_wr = 0, p_rd = 0, d_wr = 0, d_rd = 0;
    int cyc = 0;
    logic        samp_empty = 1'b1;
    logic [15:0] samp_ptr = '0;

    assign ptr_fifo_empty = (p_wr == p_rd);

    always @(posedge clk) begin
        if (ptr_fifo_rd) begin
            ptr_fifo_dout <= pmem[p_rd];
            p_rd <= p_rd + 1;
        end
        if (data_fifo_rd) begin
            data_fifo_dout <= dmem[d_rd];
            d_rd <= d_rd + 1;
        end
    end

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        samp_empty <= ptr_fifo_empty;
        samp_ptr   <= pmem[p_rd];
    end

    // Expected control flags per cycle: {ptr_rd, data_rd, dv, sof, busy, len_err}.
    bit [5:0]   expf [int];
    logic [8:0] expb [$];
    bit         fc_inc [int];
    int idle_from = 1 << 30;
    int m_rd = 0;
    int m_fc = 0;
    bit prev_rstn = 1'b0;

    int n_prd = 0, n_drd = 0, n_dv = 0, n_sof = 0, n_err = 0;
    int last_drd_cyc = 0, last_gap = 0;
    logic [7:0] sof_data = '0, last_data = '0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int padded(input int len);
        return ((len + 63) / 64) * 64;
    endfunction

    task automatic mark(input int cy, input int b);
        bit [5:0] t;
        t = expf.exists(cy) ? expf[cy] : 6'd0;
        t[b] = 1'b1;
        expf[cy] = t;
    endtask

    // Frame whose pointer pop happens in cycle c.
    task automatic schedule(input int c, input int len);
        int p;
        p = padded(len);
        mark(c, 5);
        if (len == 0) begin
            mark(c, 1);
            mark(c + 1, 1);
            mark(c + 1, 0);
            idle_from = c + 2;
        end else begin
            for (int t = c; t <= c + 1 + p + IFG; t++) mark(t, 1);
            for (int t = c + 2; t <= c + 1 + p; t++) mark(t, 4);
            for (int t = c + 3; t <= c + 2 + len; t++) mark(t, 3);
            mark(c + 3, 2);
            for (int i = 0; i < len; i++) expb.push_back({(i == 0), dmem[m_rd + i]});
            m_rd += p;
            fc_inc[c + 2 + p] = 1'b1;
            idle_from = c + 2 + p + IFG;
        end
    endtask

    task automatic step();
        bit [5:0] f;
        int eb;
        @(negedge clk);
        if (!rstn) begin
            check("reset_outputs",
                  int'({ptr_fifo_rd, data_fifo_rd, tx_dv, tx_sof, busy, len_err, tx_data}), 0);
`ifdef EGRESS_FRAME_CNT_EN
            check("reset_frame_cnt", int'(frame_cnt), 0);
`endif
            expf.delete();
            expb.delete();
            fc_inc.delete();
            idle_from = 1 << 30;
            m_fc = 0;
            prev_rstn = 1'b0;
            return;
        end
        if (!prev_rstn) idle_from = cyc + 1;
        prev_rstn = 1'b1;
        if (cyc - 1 >= idle_from && !samp_empty) schedule(cyc, int'(samp_ptr[11:0]));
        f = expf.exists(cyc) ? expf[cyc] : 6'd0;
        check("ctrl_flags", int'({ptr_fifo_rd, data_fifo_rd, tx_dv, tx_sof, busy, len_err}), int'(f));
        if (tx_dv) begin
            eb = (expb.size() > 0) ? int'(expb.pop_front()) : -1;
            check("tx_byte", int'({tx_sof, tx_data}), eb);
        end
`ifdef EGRESS_FRAME_CNT_EN
        if (fc_inc.exists(cyc)) m_fc = (m_fc + 1) & 16'hFFFF;
        check("frame_cnt", int'(frame_cnt), m_fc);
`endif
        if (ptr_fifo_rd) begin
            if (n_drd > 0) last_gap = cyc - last_drd_cyc;
            n_prd++;
        end
        if (data_fifo_rd) begin
            n_drd++;
            last_drd_cyc = cyc;
        end
        if (tx_dv) begin
            n_dv++;
            last_data = tx_data;
        end
        if (tx_sof) begin
            n_sof++;
            sof_data = tx_data;
        end
        if (len_err) n_err++;
    endtask

    task automatic push_frame(input int len);
        int p;
        p = padded(len);
        for (int i = 0; i < p; i++)
            dmem[d_wr + i] = (i == 0) ? 8'h0F : (i == 1) ? 8'h7E : (i < len) ? 8'(i) : 8'hA5;
        d_wr += p;
        pmem[p_wr] = 16'hA000 | 16'(len);
        p_wr++;
    endtask

    task automatic wait_idle(input int nframes);
        int a;
        bit done;
        a = n_prd;
        done = 1'b0;
        for (int n = 0; n < 8000 && !done; n++) begin
            step();
            if (n_prd - a >= nframes && !busy) done = 1'b1;
        end
        if (!done) check("frame_timeout", 0, 1);
    endtask

    task automatic run_frame(input int len, input int exp_rd, input int exp_dv,
                             input logic [7:0] exp_last);
        int a_drd, a_dv, a_sof;
        a_drd = n_drd;
        a_dv  = n_dv;
        a_sof = n_sof;
        push_frame(len);
        wait_idle(1);
        check("frame_reads", n_drd - a_drd, exp_rd);
        check("frame_dv", n_dv - a_dv, exp_dv);
        check("frame_sof", n_sof - a_sof, 1);
        check("sof_data", int'(sof_data), 8'h0F);
        check("last_data", int'(last_data), int'(exp_last));
    endtask

    initial begin
        int a_drd, a_prd, a_err, a_dv;
        bit hit;
        rstn = 1'b0;
        repeat (3) step();
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) step();

        run_frame(126, 128, 126, 8'h7D);
        run_frame(129, 192, 129, 8'h80);
        run_frame(128, 128, 128, 8'h7F);

        push_frame(64);
        push_frame(70);
        wait_idle(2);
        check("ifg_gap_ok", int'(last_gap >= IFG + 1), 1);

        a_drd = n_drd;
        a_err = n_err;
        push_frame(0);
        wait_idle(1);
        check("len0_err", n_err - a_err, 1);
        check("len0_reads", n_drd - a_drd, 0);
`ifdef EGRESS_FRAME_CNT_EN
        check("len0_frame_cnt", int'(frame_cnt), 5);
`endif

        a_dv = n_dv;
        push_frame(126);
        hit = 1'b0;
        for (int n = 0; n < 500 && !hit; n++) begin
            step();
            if (n_dv - a_dv >= 40) hit = 1'b1;
        end
        if (!hit) check("midframe_timeout", 0, 1);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1 check("async_reset",
                 int'({ptr_fifo_rd, data_fifo_rd, tx_dv, tx_sof, busy, len_err, tx_data}), 0);
        d_wr = d_rd;
        m_rd = d_wr;
        repeat (3) step();
        @(posedge clk);
        #1 rstn = 1'b1;
        a_drd = n_drd;
        a_prd = n_prd;
        repeat (20) step();
        check("post_reset_reads", n_drd - a_drd, 0);
        check("post_reset_ptr_rd", n_prd - a_prd, 0);

        run_frame(64, 64, 64, 8'h3F);
`ifdef EGRESS_FRAME_CNT_EN
        check("final_frame_cnt", int'(frame_cnt), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
